// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtraction controller: feeds an external full-subtractor one bit
// per clock, LSB first, and collects the difference and final borrow.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             fsA,
  output logic             fsB,
  output logic             fsBorrowIn,
  input  logic             fsDifference,
  input  logic             fsBorrowOut,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrowOut
);

  // state | meaning
  // IDLE  | waiting for start; results from the last operation held
  // SHIFT | one operand bit pair per clock through the external stage
  // DONE  | single-cycle done pulse, then back to IDLE

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] diff_reg;
  logic [WIDTH-1:0] diff_shift;
  logic             borrow_reg;
  logic             borrow_out_reg;
  logic [CNT_W-1:0] bit_count;
  logic             last_bit;

  assign last_bit = (bit_count == LAST_BIT);

  // Shift operator instead of a part-select keeps WIDTH=1 legal.
  always_comb begin
    diff_shift = diff_reg >> 1;
    diff_shift[WIDTH-1] = fsDifference;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fsA        = 1'b0;
    fsB        = 1'b0;
    fsBorrowIn = 1'b0;
    busy       = (state == SHIFT) || (state == DONE);
    done       = (state == DONE);
    if (state == SHIFT) begin
      fsA        = a_reg[0];
      fsB        = b_reg[0];
      fsBorrowIn = borrow_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      a_reg          <= '0;
      b_reg          <= '0;
      diff_reg       <= '0;
      borrow_reg     <= 1'b0;
      borrow_out_reg <= 1'b0;
      bit_count      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg      <= A;
            b_reg      <= B;
            borrow_reg <= 1'b0;
            bit_count  <= '0;
          end
        end
        SHIFT: begin
          diff_reg   <= diff_shift;
          borrow_reg <= fsBorrowOut;
          a_reg      <= a_reg >> 1;
          b_reg      <= b_reg >> 1;
          bit_count  <= bit_count + 1'b1;
          if (last_bit) borrow_out_reg <= fsBorrowOut;
        end
        default: ;
      endcase
    end
  end

  assign difference = diff_reg;
  assign borrowOut  = borrow_out_reg;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl: WIDTH=8 and WIDTH=1 instances,
// each wired to a behavioural full-subtractor.
module tb_serial_subtractor_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       fs_a8, fs_b8, fs_bin8, fs_d8, fs_bo8, busy8, done8, bo8;
  logic [7:0] diff8;
  logic       fs_a1, fs_b1, fs_bin1, fs_d1, fs_bo1, busy1, done1, bo1;
  logic [0:0] diff1;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  assign fs_d8  = fs_a8 ^ fs_b8 ^ fs_bin8;
  assign fs_bo8 = (~fs_a8 & fs_b8) | (~(fs_a8 ^ fs_b8) & fs_bin8);
  assign fs_d1  = fs_a1 ^ fs_b1 ^ fs_bin1;
  assign fs_bo1 = (~fs_a1 & fs_b1) | (~(fs_a1 ^ fs_b1) & fs_bin1);

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8),
    .fsA(fs_a8), .fsB(fs_b8), .fsBorrowIn(fs_bin8),
    .fsDifference(fs_d8), .fsBorrowOut(fs_bo8),
    .busy(busy8), .done(done8), .difference(diff8), .borrowOut(bo8)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .A(a1), .B(b1),
    .fsA(fs_a1), .fsB(fs_b1), .fsBorrowIn(fs_bin1),
    .fsDifference(fs_d1), .fsBorrowOut(fs_bo1),
    .busy(busy1), .done(done1), .difference(diff1), .borrowOut(bo1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start at the next edge (edge 0) and follow the operation for 10 edges.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp_d, input logic exp_bo,
                      input logic chk_fsa, input logic [7:0] exp_fsa);
    logic [7:0] fsa_seq;
    fsa_seq = '0;
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k <= 8) fsa_seq[k-1] = fs_a8;
      @(posedge clk); #1;
      check_val({tag, " done"}, {31'd0, done8}, {31'd0, (k == 8)});
      check_val({tag, " busy"}, {31'd0, busy8}, {31'd0, (k <= 8)});
      if (k == 8) begin
        check_val({tag, " fs_idle"}, {29'd0, fs_a8, fs_b8, fs_bin8}, 32'd0);
        check_val({tag, " diff"}, {24'd0, diff8}, {24'd0, exp_d});
        check_val({tag, " borrow"}, {31'd0, bo8}, {31'd0, exp_bo});
      end
      if (k == 10) begin
        check_val({tag, " diff_hold"}, {24'd0, diff8}, {24'd0, exp_d});
        check_val({tag, " borrow_hold"}, {31'd0, bo8}, {31'd0, exp_bo});
      end
    end
    if (chk_fsa) check_val({tag, " fsa_seq"}, {24'd0, fsa_seq}, {24'd0, exp_fsa});
  endtask

  initial begin
    reset = 1'b1; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst busy", {31'd0, busy8}, 32'd0);
    check_val("rst done", {31'd0, done8}, 32'd0);
    check_val("rst diff", {24'd0, diff8}, 32'd0);
    check_val("rst borrow", {31'd0, bo8}, 32'd0);
    check_val("rst fs", {29'd0, fs_a8, fs_b8, fs_bin8}, 32'd0);
    reset = 1'b0;

    // First edge after reset release carries the start.
    run8("5-3", 8'd5, 8'd3, 8'd2, 1'b0, 1'b1, 8'b0000_0101);
    run8("3-5", 8'd3, 8'd5, 8'hFE, 1'b1, 1'b0, 8'h00);
    run8("ff-0", 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00);
    run8("0-0", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);

    // start held for 20 cycles; operands changed mid-SHIFT.
    @(negedge clk);
    a8 = 8'd10; b8 = 8'd4; start8 = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 19; k++) begin
      if (k == 3) begin a8 = 8'h20; b8 = 8'h01; end
      if (k == 13) begin a8 = 8'h01; b8 = 8'h02; end
      @(posedge clk); #1;
      check_val("held done", {31'd0, done8}, {31'd0, (k == 8 || k == 18)});
      if (k == 8) begin
        check_val("held diff1", {24'd0, diff8}, 32'h06);
        check_val("held borrow1", {31'd0, bo8}, 32'd0);
      end
      if (k == 18) begin
        check_val("held diff2", {24'd0, diff8}, 32'h1F);
        check_val("held borrow2", {31'd0, bo8}, 32'd0);
      end
    end
    start8 = 1'b0;
    @(posedge clk); #1;
    check_val("held idle", {31'd0, busy8}, 32'd0);

    // Reset in the middle of SHIFT.
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h0F; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("abort busy", {31'd0, busy8}, 32'd0);
    check_val("abort diff", {24'd0, diff8}, 32'd0);
    check_val("abort borrow", {31'd0, bo8}, 32'd0);
    check_val("abort fs", {29'd0, fs_a8, fs_b8, fs_bin8}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check_val("abort no_done", {30'd0, done8, busy8}, 32'd0);
    end
    run8("7-7", 8'd7, 8'd7, 8'd0, 1'b0, 1'b0, 8'h00);

    // WIDTH=1 instance: 0 - 1.
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check_val("w1 busy", {31'd0, busy1}, 32'd1);
    check_val("w1 fsb", {31'd0, fs_b1}, 32'd1);
    @(posedge clk); #1;
    check_val("w1 done", {31'd0, done1}, 32'd1);
    check_val("w1 diff", {31'd0, diff1}, 32'd1);
    check_val("w1 borrow", {31'd0, bo1}, 32'd1);
    @(posedge clk); #1;
    check_val("w1 done_off", {31'd0, done1}, 32'd0);
    check_val("w1 diff_hold", {31'd0, diff1}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
